// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU: op codes, FSM states and
// op decode helpers used by the top level and the digit slice.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1111;

    // Low two op bits select the digit function; bit 2 inverts B.
    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_XOR = 2'b10;
    localparam logic [1:0] SEL_SUM = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR) ||
               (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

    function automatic logic needs_carry_in(input logic [3:0] op);
        return (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_digit.sv
// One DIGIT-wide combinational slice: logic ops or ripple add with optional
// B inversion, exporting carry-out and the carry into the slice MSB.
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic [2:0]       op,
    input  logic             cin,
    output logic [DIGIT-1:0] res_d,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT-1:0] b_eff;
    logic [DIGIT:0]   sum;

    assign b_eff = op[2] ? ~b_d : b_d;
    assign sum   = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT{1'b0}}, cin};
    assign cout  = sum[DIGIT];

    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the sum.
    assign c_msb = sum[DIGIT-1] ^ a_d[DIGIT-1] ^ b_eff[DIGIT-1];

    always_comb begin
        res_d = '0;
        case (op[1:0])
            SEL_AND: res_d = a_d & b_eff;
            SEL_OR:  res_d = a_d | b_eff;
            SEL_XOR: res_d = a_d ^ b_eff;
            SEL_SUM: res_d = sum[DIGIT-1:0];
            default: res_d = '0;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Digit-serial ALU: processes DIGIT bits per clock with the ripple carry held
// in a register, valid/ready on both sides, flags formed on the last digit.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for an operation; in_ready high
// RUN     | one digit per cycle, LSB first, NDIG cycles
// DONE    | result/flags valid and held until out_ready
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             op_err
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 2) ? $clog2(NDIG) : 1;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [3:0]       op_reg;
    logic             carry_reg;
    logic [CW-1:0]    dig_left;

    logic             accept;
    logic             last_dig;

    logic [DIGIT-1:0] d_res;
    logic             d_cout;
    logic             d_c_msb;

    logic [WIDTH-1:0] full_res;
    logic [WIDTH-1:0] fin_res;
    logic             fin_carry;
    logic             fin_ovf;
    logic             fin_err;
    logic             fin_zero;
    logic             fin_neg;
    logic             ovf_raw;
    logic             slt_bit;

    assign accept   = in_valid & in_ready;
    assign last_dig = (dig_left == '0);

    alu_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d   (a_sh[DIGIT-1:0]),
        .b_d   (b_sh[DIGIT-1:0]),
        .op    (op_reg[2:0]),
        .cin   (carry_reg),
        .res_d (d_res),
        .cout  (d_cout),
        .c_msb (d_c_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_RUN;
            ST_RUN:  if (last_dig) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = in_valid ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Final digit lands on top of the shift register to form the whole word.
    assign full_res = {d_res, res_sh[WIDTH-1:DIGIT]};
    assign ovf_raw  = d_c_msb ^ d_cout;
    assign slt_bit  = d_res[DIGIT-1] ^ ovf_raw;

    always_comb begin
        fin_res   = full_res;
        fin_carry = 1'b0;
        fin_ovf   = 1'b0;
        fin_err   = 1'b0;
        if (!is_legal_op(op_reg)) begin
            fin_res = '0;
            fin_err = 1'b1;
        end else if (is_arith_op(op_reg)) begin
            fin_carry = d_cout;
            fin_ovf   = ovf_raw;
            if (op_reg == OP_SLT) begin
                fin_res = {{(WIDTH-1){1'b0}}, slt_bit};
            end
        end
    end

    // An illegal op reports a zero result but every flag stays low.
    assign fin_zero = ~fin_err & (fin_res == '0);
    assign fin_neg  = ~fin_err & fin_res[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_reg    <= '0;
            carry_reg <= 1'b0;
            dig_left  <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            op_err    <= 1'b0;
        end else if (accept) begin
            a_sh      <= a;
            b_sh      <= b;
            op_reg    <= op;
            carry_reg <= needs_carry_in(op);
            dig_left  <= CW'(NDIG - 1);
        end else if (state == ST_RUN) begin
            a_sh      <= a_sh >> DIGIT;
            b_sh      <= b_sh >> DIGIT;
            carry_reg <= d_cout;
            dig_left  <= dig_left - 1'b1;
            if (last_dig) begin
                res_sh   <= fin_res;
                zero     <= fin_zero;
                carry    <= fin_carry;
                overflow <= fin_ovf;
                negative <= fin_neg;
                op_err   <= fin_err;
            end else begin
                res_sh   <= full_res;
            end
        end
    end

    assign result = res_sh;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_alu_multicycle;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             negative;
    logic             op_err;

    int n_checks = 0;
    int n_errors = 0;

    alu_multicycle #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: flags packed as {op_err, negative, overflow, carry, zero}.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [3:0] mop,
                         output logic [31:0] r, output logic [4:0] f);
        logic [32:0] s;
        logic        c;
        logic        v;
        logic        bad;
        r = '0; c = 1'b0; v = 1'b0; bad = 1'b0; s = '0;
        case (mop)
            4'b0000: r = ma & mb;
            4'b0001: r = ma | mb;
            4'b0010: r = ma ^ mb;
            4'b0011: begin
                s = {1'b0, ma} + {1'b0, mb};
                r = s[31:0]; c = s[32];
                v = (ma[31] == mb[31]) && (r[31] != ma[31]);
            end
            4'b0111, 4'b1111: begin
                s = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (ma[31] != mb[31]) && (r[31] != ma[31]);
                if (mop == 4'b1111) r = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
            end
            default: bad = 1'b1;
        endcase
        if (bad) f = 5'b10000;
        else     f = {1'b0, r[31], v, c, (r == 32'd0)};
    endtask

    task automatic check_out(input logic [31:0] ta, input logic [31:0] tb_, input logic [3:0] top,
                             input string tag);
        logic [31:0] er;
        logic [4:0]  ef;
        model(ta, tb_, top, er, ef);
        chk({tag, " result"}, result, er);
        chk({tag, " flags"}, 32'({op_err, negative, overflow, carry, zero}), 32'(ef));
    endtask

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic [3:0] top);
        int cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("in_ready before accept", 32'(in_ready), 32'd1);
        a = ta; b = tb_; op = top; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid after release", 32'(out_valid), 32'd0);
    endtask

    // Full transaction; garbage with in_valid high while busy must be ignored.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [3:0] top,
                          input int hold, input string tag);
        int cyc;
        send(ta, tb_, top);
        in_valid = 1'b1; a = $urandom; b = $urandom; op = 4'($urandom);
        wait_out(cyc);
        chk({tag, " latency"}, 32'(cyc), 32'd4);
        check_out(ta, tb_, top, tag);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, " in_ready held"}, 32'(in_ready), 32'd0);
            chk({tag, " out_valid held"}, 32'(out_valid), 32'd1);
            check_out(ta, tb_, top, {tag, " held"});
        end
        release_out();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [3:0]  vop;
        logic [31:0] vres;
        string       name;
    } vec_t;

    vec_t dir[10];

    initial begin
        int          cyc;
        int          seen;
        logic [3:0]  legal[6];

        legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1111};
        dir[0] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 32'hF000F000, "and"};
        dir[1] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 32'hFFF0FFF0, "or"};
        dir[2] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b0010, 32'h0FF00FF0, "xor"};
        dir[3] = '{32'hFFFFFFFF, 32'h00000001, 4'b0011, 32'h00000000, "add wrap"};
        dir[4] = '{32'h7FFFFFFF, 32'h00000001, 4'b0011, 32'h80000000, "add ovf"};
        dir[5] = '{32'h80000000, 32'h00000001, 4'b0111, 32'h7FFFFFFF, "sub ovf"};
        dir[6] = '{32'h00000000, 32'h00000001, 4'b0111, 32'hFFFFFFFF, "sub borrow"};
        dir[7] = '{32'hFFFFFFFF, 32'h00000001, 4'b1111, 32'h00000001, "slt neg"};
        dir[8] = '{32'h7FFFFFFF, 32'h80000000, 4'b1111, 32'h00000000, "slt ovf"};
        dir[9] = '{32'h12345678, 32'h9ABCDEF0, 4'b1000, 32'h00000000, "illegal"};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flags", 32'({op_err, negative, overflow, carry, zero}), 32'd0);

        foreach (dir[i]) begin
            run_op(dir[i].va, dir[i].vb, dir[i].vop, 0, dir[i].name);
        end
        // Result constants from the plan, checked separately from the model.
        foreach (dir[i]) begin
            send(dir[i].va, dir[i].vb, dir[i].vop);
            wait_out(cyc);
            chk({dir[i].name, " const"}, result, dir[i].vres);
            release_out();
        end

        // Backpressure then back-to-back hand-off in the same cycle.
        send(32'h00000005, 32'h00000003, 4'b0111);
        in_valid = 1'b1; a = 32'hDEADBEEF; b = 32'h1; op = 4'b0011;
        wait_out(cyc);
        chk("b2b first latency", 32'(cyc), 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp in_ready", 32'(in_ready), 32'd0);
            check_out(32'h00000005, 32'h00000003, 4'b0111, "bp");
        end
        a = 32'h40000000; b = 32'h40000000; op = 4'b0011; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("b2b in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b no bubble", 32'(out_valid), 32'd0);
        wait_out(cyc);
        chk("b2b second latency", 32'(cyc), 32'd4);
        check_out(32'h40000000, 32'h40000000, 4'b0011, "b2b second");
        release_out();

        // Reset while digit 2 is about to be processed.
        send(32'h11111111, 32'h22222222, 4'b0011);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun rst out_valid", 32'(out_valid), 32'd0);
        chk("midrun rst in_ready", 32'(in_ready), 32'd1);
        chk("midrun rst result", result, 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        chk("midrun rst no output", 32'(seen), 32'd0);
        run_op(32'd2, 32'd3, 4'b0011, 0, "post rst add");
        chk("post rst add const", result, 32'd5);

        for (int n = 0; n < 150; n++) begin
            logic [3:0] rop;
            rop = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal[$urandom_range(0, 5)];
            run_op(rand_operand(), rand_operand(), rop, $urandom_range(0, 3), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, digit-serial successor to the single-bit ALU slice used in the single-cycle processor datapath.
- Computes AND/OR/XOR/ADD/SUB/SLT on WIDTH-bit operands, DIGIT bits per clock.
- Ripple carry is held in a register between digits.
- Valid/ready handshakes on both input and output; produces zero/carry/overflow/negative flags for the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of DIGIT.
- DIGIT, 8, bits processed per cycle; NDIG = WIDTH/DIGIT, must be ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  4  operation code.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- carry  output  1  adder carry-out of MSB (SUB: 1 = no borrow).
- overflow  output  1  signed overflow (carry into MSB xor carry out of MSB).
- negative  output  1  result[WIDTH-1].
- op_err  output  1  op was not a legal encoding.

Behaviour:
- Op encoding: Op[2] inverts B; Op[1:0] & 3 selects add.
  - 4'b0000 AND, 4'b0001 OR, 4'b0010 XOR.
  - 4'b0011 ADD (carry-in 0).
  - 4'b0111 SUB (B inverted, carry-in 1).
  - 4'b1111 SLT: signed subtract; result = {0..0, sum_msb ^ overflow}.
  - All other codes illegal: result 0, flags 0, op_err 1.
- Reset: state IDLE; in_ready=1; out_valid=0; result, all flags, op_err = 0; operand and carry registers cleared.
- Reset has priority over everything, including mid-RUN; an in-flight operation is discarded with no output.
- FSM IDLE -> RUN -> DONE:
  - IDLE: in_ready=1. On in_valid: latch a, b, op; carry_reg = (SUB|SLT); digit index k=0; go to RUN.
  - RUN: each cycle processes digit k (bits k*DIGIT+DIGIT-1 : k*DIGIT) through the digit slice, writes the digit into the result shift register, updates carry_reg, increments k. After digit NDIG-1: compute flags, apply the SLT substitution, go to DONE.
  - DONE: out_valid=1; result/flags held stable while out_ready=0.
    - On out_ready, if in_valid is low: go to IDLE.
    - On out_ready with in_valid high: in_ready=1 this cycle; new operation accepted in the same cycle; go directly to RUN (back-to-back, no bubble).
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Latency: acceptance edge to out_valid asserted = NDIG cycles.
  - Sustained throughput: one operation per NDIG+1 cycles, with out_ready tied high.
- Flag rules:
  - Logic ops: carry=0, overflow=0.
  - SLT: carry/overflow from the underlying subtraction; zero/negative computed from the final SLT result.
- in_valid/a/b/op are ignored while in RUN, and in DONE when out_ready=0.

Decomposition:
- Package alu_pkg: op code localparams (OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SLT), FSM state encoding (ST_IDLE, ST_RUN, ST_DONE), and a legal-op check function.
- Sub-module alu_digit: combinational, DIGIT-wide.
  - Inputs: a_d, b_d, op, cin.
  - Outputs: res_d, cout, and c_msb (carry into the top bit, used on the last digit for overflow).
  - Instantiated once; the top level holds the FSM, operand shift registers, carry register and flag logic.

Test Plan (WIDTH=32, DIGIT=8):
- Logic ops, a=0xF0F0F0F0, b=0xFF00FF00:
  - AND -> 0xF000F000; OR -> 0xFFF0FFF0; XOR -> 0x0FF00FF0.
  - carry=0, overflow=0; out_valid exactly 4 cycles after accept.
- ADD 0xFFFFFFFF+0x00000001 -> result 0, zero=1, carry=1, overflow=0, negative=0.
- ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1, negative=1, carry=0.
- SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1, carry=1.
- SUB 0-1 -> 0xFFFFFFFF, carry=0, negative=1.
- SLT a=0xFFFFFFFF, b=1 -> result 1.
- SLT a=0x7FFFFFFF, b=0x80000000 -> result 0 (overflow path), zero=1.
- Backpressure: out_ready low 3 cycles in DONE -> result/flags stable, in_ready=0.
- Back-to-back: raise out_ready with in_valid high -> second op accepted in the same cycle; its result appears 4 cycles later.
- rst pulsed at RUN digit 2 -> next cycle out_valid=0, in_ready=1, result=0; a following ADD 2+3 -> 5.
- Illegal op 4'b1000 -> after 4 cycles: result 0, op_err=1, all flags 0.
